// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port integer register file with write bypass and busy scoreboard
module regfile_scoreboard #(
  parameter int REG_NUM    = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [RD_PORTS-1:0]              rd_busy,
  input  logic [WR_PORTS-1:0]              wr_en,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0]   wr_data,
  input  logic                             iss_en,
  input  logic [ADDR_WIDTH-1:0]            iss_addr,
  output logic                             iss_ready,
  input  logic                             flush,
  output logic [$clog2(REG_NUM+1)-1:0]     busy_count
);
  localparam int CNT_W = $clog2(REG_NUM + 1);

  logic [DATA_WIDTH-1:0] rf     [1:REG_NUM-1];
  logic [DATA_WIDTH-1:0] wr_val [1:REG_NUM-1];
  logic [REG_NUM-1:1]    wr_hit;
  logic [REG_NUM-1:0]    busy, busy_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  iss_valid, iss_hit_busy, iss_hit_wr, iss_set;

  // Out-of-range addresses fold onto register 0, so every path treats them alike.
  function automatic int reg_idx(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < REG_NUM) ? int'(a) : 0;
  endfunction

  // Per-register write decode; later ports overwrite earlier ones, giving high-index priority.
  always_comb begin
    wr_hit = '0;
    for (int r = 1; r < REG_NUM; r++) wr_val[r] = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (wr_en[i] && reg_idx(wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) == r) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (reg_idx(rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]) == r) begin
          if (BYPASS != 0 && wr_hit[r]) begin
            rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wr_val[r];
            rd_busy[k] = 1'b0;
          end else begin
            rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rf[r];
            rd_busy[k] = busy[r];
          end
        end
      end
    end
  end

  // A writeback landing this cycle resolves the WAW hazard, so issue may proceed.
  always_comb begin
    iss_valid    = reg_idx(iss_addr) != 0;
    iss_hit_busy = 1'b0;
    iss_hit_wr   = 1'b0;
    for (int r = 1; r < REG_NUM; r++) begin
      if (reg_idx(iss_addr) == r) begin
        iss_hit_busy = busy[r];
        iss_hit_wr   = wr_hit[r];
      end
    end
    iss_ready = !flush && (!iss_valid || !iss_hit_busy || iss_hit_wr);
    iss_set   = iss_en && iss_ready && iss_valid;

    busy_nxt    = busy;
    busy_nxt[0] = 1'b0;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (iss_set && reg_idx(iss_addr) == r) busy_nxt[r] = 1'b1;
        else if (wr_hit[r])                     busy_nxt[r] = 1'b0;
      end
    end

    cnt_nxt = '0;
    for (int r = 0; r < REG_NUM; r++) cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
      for (int r = 1; r < REG_NUM; r++) rf[r] <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
      for (int r = 1; r < REG_NUM; r++) begin
        if (wr_hit[r]) rf[r] <= wr_val[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard, bypass and non-bypass builds
module tb_regfile_scoreboard;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int RN = 24;
  localparam int RP = 2;
  localparam int WP = 2;
  localparam int CW = $clog2(RN + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*DW-1:0] rd_data, rd_data_nb;
  logic [RP-1:0]    rd_busy, rd_busy_nb;
  logic [WP-1:0]    wr_en;
  logic [WP*AW-1:0] wr_addr;
  logic [WP*DW-1:0] wr_data;
  logic             iss_en, iss_ready, iss_ready_nb, flush;
  logic [AW-1:0]    iss_addr;
  logic [CW-1:0]    busy_count, busy_count_nb;

  regfile_scoreboard #(.REG_NUM(RN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .RD_PORTS(RP), .WR_PORTS(WP), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .iss_ready(iss_ready), .flush(flush), .busy_count(busy_count));

  regfile_scoreboard #(.REG_NUM(RN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .RD_PORTS(RP), .WR_PORTS(WP), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .iss_ready(iss_ready_nb), .flush(flush), .busy_count(busy_count_nb));

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic [63:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
    else check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[i] = 1'b1;
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_en = 1'b1;
    iss_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [63:0] rd_d(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  function automatic logic [63:0] rd_d_nb(input int k);
    return rd_data_nb[k*DW +: DW];
  endfunction

  initial begin
    idle();
    set_rd(0, 5);
    expect_out("rst_count", 0);
    expect_out("rst_iss_ready", 1);
    expect_out("rst_rd_x5", 0);
    #2;
    pop_check(64'(busy_count)); pop_check(64'(iss_ready)); pop_check(rd_d(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // write x5 and attempt x0 in the same cycle
    set_wr(0, 5, 64'h1234); set_wr(1, 0, 64'hFFFF); set_rd(0, 5); set_rd(1, 0);
    expect_out("byp_x5", 64'h1234); expect_out("nb_old_x5", 0); expect_out("x0_during_wr", 0);
    #1; pop_check(rd_d(0)); pop_check(rd_d_nb(0)); pop_check(rd_d(1));
    tick();

    set_rd(0, 5); set_rd(1, 0);
    expect_out("x5", 64'h1234); expect_out("x5_busy", 0); expect_out("x0", 0);
    expect_out("nb_x5", 64'h1234); expect_out("nb_x0", 0);
    #1; pop_check(rd_d(0)); pop_check(64'(rd_busy[0])); pop_check(rd_d(1));
    pop_check(rd_d_nb(0)); pop_check(rd_d_nb(1));
    tick();

    set_wr(0, 7, 64'hABCD); set_rd(1, 7);
    expect_out("byp_x7", 64'hABCD); expect_out("byp_x7_busy", 0); expect_out("nb_x7_old", 0);
    #1; pop_check(rd_d(1)); pop_check(64'(rd_busy[1])); pop_check(rd_d_nb(1));
    tick();

    set_rd(1, 7);
    expect_out("nb_x7_new", 64'hABCD);
    #1; pop_check(rd_d_nb(1));
    tick();

    // scoreboard: issue, WAW re-issue, writeback
    issue(3);
    expect_out("iss_x3_ready", 1);
    #1; pop_check(64'(iss_ready));
    tick();

    issue(3); set_rd(0, 3);
    expect_out("reiss_x3_ready", 0); expect_out("x3_busy", 1); expect_out("count_x3", 1);
    #1; pop_check(64'(iss_ready)); pop_check(64'(rd_busy[0])); pop_check(64'(busy_count));
    tick();

    set_wr(0, 3, 64'h55); set_rd(0, 3);
    expect_out("count_after_reiss", 1); expect_out("nb_x3_busy_wb", 1); expect_out("byp_x3_busy_wb", 0);
    #1; pop_check(64'(busy_count)); pop_check(64'(rd_busy_nb[0])); pop_check(64'(rd_busy[0]));
    tick();

    set_rd(0, 3);
    expect_out("x3_after_wb", 64'h55); expect_out("x3_busy_after_wb", 0); expect_out("count_after_wb", 0);
    #1; pop_check(rd_d(0)); pop_check(64'(rd_busy[0])); pop_check(64'(busy_count));
    tick();

    // issue and writeback to the same busy register in one cycle
    issue(9);
    tick();
    issue(9); set_wr(1, 9, 64'h99);
    expect_out("iss_x9_with_wb", 1); expect_out("count_x9", 1);
    #1; pop_check(64'(iss_ready)); pop_check(64'(busy_count));
    tick();

    set_rd(0, 9);
    expect_out("x9_data", 64'h99); expect_out("x9_still_busy", 1); expect_out("count_x9_kept", 1);
    #1; pop_check(rd_d(0)); pop_check(64'(rd_busy[0])); pop_check(64'(busy_count));
    tick();

    set_wr(0, 9, 64'h9A);
    tick();

    // three issues, then flush with a competing issue
    issue(1);
    expect_out("count_before_x1", 0);
    #1; pop_check(64'(busy_count));
    tick();
    issue(2);
    tick();
    issue(4);
    tick();
    flush = 1'b1; issue(6);
    expect_out("count_three", 3); expect_out("iss_ready_flush", 0); expect_out("nb_iss_ready_flush", 0);
    #1; pop_check(64'(busy_count)); pop_check(64'(iss_ready)); pop_check(64'(iss_ready_nb));
    tick();

    set_rd(0, 6); set_rd(1, 1);
    expect_out("x6_not_busy", 0); expect_out("x1_flushed", 0); expect_out("count_flushed", 0);
    #1; pop_check(64'(rd_busy[0])); pop_check(64'(rd_busy[1])); pop_check(64'(busy_count));
    tick();

    // both write ports hit x10, port 1 wins
    set_wr(0, 10, 64'h1); set_wr(1, 10, 64'h2); set_rd(0, 10);
    expect_out("byp_x10_prio", 2);
    #1; pop_check(rd_d(0));
    tick();

    set_rd(0, 10);
    expect_out("x10_prio", 2); expect_out("nb_x10_prio", 2);
    #1; pop_check(rd_d(0)); pop_check(rd_d_nb(0));
    tick();

    // address beyond REG_NUM behaves like x0
    set_wr(0, 30, 64'h77); issue(30); set_rd(1, 30);
    expect_out("iss_x30_ready", 1); expect_out("byp_x30", 0);
    #1; pop_check(64'(iss_ready)); pop_check(rd_d(1));
    tick();

    set_rd(0, 30);
    expect_out("x30_data", 0); expect_out("x30_busy", 0); expect_out("count_x30", 0);
    #1; pop_check(rd_d(0)); pop_check(64'(rd_busy[0])); pop_check(64'(busy_count));
    tick();

    // async reset between edges
    issue(11);
    tick();
    set_rd(0, 10); set_rd(1, 11);
    expect_out("count_x11", 1); expect_out("x11_busy", 1);
    #1; pop_check(64'(busy_count)); pop_check(64'(rd_busy[1]));
    rst_n = 1'b0;
    expect_out("arst_count", 0); expect_out("arst_x10", 0);
    expect_out("arst_x11_busy", 0); expect_out("arst_iss_ready", 1);
    #1; pop_check(64'(busy_count)); pop_check(rd_d(0));
    pop_check(64'(rd_busy[1])); pop_check(64'(iss_ready));
    rst_n = 1'b1;
    tick();

    check("sb_drain", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
